button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 2, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 10, giving the number of tick_1ms strobes a raw level must hold stable to be accepted (range 1..1023).
REQ-003 The block SHALL have parameter HOLD_TICKS, default 1000, giving the tick_1ms strobes after an accepted press at which a long press is flagged (range 1..65535).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports listed in this order:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick_1ms  in  1  single-clk enable strobe, once per millisecond.
- btn_raw  in  NUM_BTN  asynchronous raw button levels; 1 = pressed.
- btn_level  out  NUM_BTN  debounced level per channel.
- press_pulse  out  NUM_BTN  one-clk pulse on each accepted press.
- release_pulse  out  NUM_BTN  one-clk pulse on each accepted release.
- hold_pulse  out  NUM_BTN  one-clk pulse when a press reaches HOLD_TICKS.

Function
REQ-005 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) SHALL feed the channel logic.
REQ-006 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter wide enough for DEBOUNCE_TICKS.
REQ-007 In IDLE with sync=1, the FSM SHALL enter PRESS_WAIT with the counter cleared; with sync=0 it SHALL stay in IDLE.
REQ-008 In PRESS_WAIT with sync=0, the FSM SHALL return to IDLE with no output pulse.
REQ-009 In PRESS_WAIT, each tick_1ms with sync=1 SHALL increment the counter; the tick that makes the count equal DEBOUNCE_TICKS SHALL move the FSM to PRESSED, set btn_level=1 and assert press_pulse for exactly that one clk edge's following cycle.
REQ-010 In PRESSED with sync=0, the FSM SHALL enter RELEASE_WAIT with the counter cleared.
REQ-011 In RELEASE_WAIT with sync=1, the FSM SHALL return to PRESSED with no press_pulse, and the hold counter SHALL keep its value.
REQ-012 In RELEASE_WAIT, each tick_1ms with sync=0 SHALL increment the counter; at DEBOUNCE_TICKS the FSM SHALL enter IDLE, clear btn_level and assert release_pulse for one cycle.
REQ-013 A sync change and a tick_1ms in the same cycle SHALL be resolved in favour of the sync change: the FSM takes the bounce transition and the tick is not counted.
REQ-014 The latency from a clean raw edge to press_pulse or release_pulse SHALL be 2 sync clocks plus 1 FSM clock plus the DEBOUNCE_TICKS ticks, with the pulse asserted the cycle after the qualifying tick.
REQ-015 press_pulse, release_pulse and hold_pulse SHALL each be high for at most one cycle per event and SHALL never be high in the same cycle on the same channel.
REQ-016 The channels SHALL not interact; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-017 When rst=1 at a clk edge, every channel SHALL go to IDLE, and the synchronizer flops, the debounce and hold counters, btn_level, press_pulse, release_pulse and hold_pulse SHALL all be cleared to 0.
REQ-018 Reset asserted mid-press SHALL drop btn_level with no release_pulse.
REQ-019 After reset, a button held high SHALL be debounced afresh and produce a press_pulse.

Configuration
REQ-020 With macro BUTTON_CONDITIONER_LONG_PRESS_EN defined, each channel SHALL have a hold counter that clears on the PRESS_WAIT to PRESSED transition and increments on tick_1ms while in PRESSED or RELEASE_WAIT.
REQ-021 With BUTTON_CONDITIONER_LONG_PRESS_EN defined, the hold counter SHALL assert hold_pulse once when it reaches HOLD_TICKS and then saturate, giving one hold_pulse per press.
REQ-022 Without BUTTON_CONDITIONER_LONG_PRESS_EN, the hold counter logic SHALL be absent, the hold_pulse port SHALL remain present and tied to 0, and all other behaviour SHALL be unchanged.

Verification
Unless stated otherwise, use NUM_BTN=2, DEBOUNCE_TICKS=3, HOLD_TICKS=5, tick_1ms every 4th clk, and the macro defined.
REQ-023 Clean press: btn_raw[0] rises and is held -> one press_pulse[0] and btn_level[0]=1 the cycle after the 3rd tick; no pulses on channel 1.
REQ-024 Bounce: btn_raw[0] toggles 1,0,1 with each level lasting 1 tick, then is held -> exactly one press_pulse[0], counted from the final rise.
REQ-025 Release glitch: while PRESSED, drop btn_raw[0] for 1 tick -> no release_pulse and no press_pulse, btn_level stays 1; a sustained drop -> release_pulse after 3 ticks.
REQ-026 Long press: hold btn_raw[1] -> press_pulse[1], then exactly one hold_pulse[1] 5 ticks later, none thereafter; rebuilt without the macro, hold_pulse stays 0.
REQ-027 Reset mid-press: assert rst while btn_level[0]=1 -> all outputs 0 next cycle with no release_pulse; with the button still held after reset, press_pulse after 2+1 clks plus 3 ticks.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, tick-based debounce FSM, press/release pulses.
// Optional long-press detection (hold_pulse) is enabled by defining BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
  parameter int NUM_BTN        = 2,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1ms,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] hold_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [NUM_BTN-1:0]            meta_q, meta_d;
  logic [NUM_BTN-1:0]            sync_q, sync_d;
  logic [NUM_BTN-1:0][1:0]       state_q, state_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            level_q, level_d;
  logic [NUM_BTN-1:0]            press_q, press_d;
  logic [NUM_BTN-1:0]            release_q, release_d;

  // Per-channel debounce FSM; a sync change always wins over a same-cycle tick.
  always_comb begin
    meta_d    = btn_raw;
    sync_d    = meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (sync_q[i]) begin
            state_d[i] = ST_PRESS_WAIT;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (tick_1ms) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ST_PRESSED;
              level_d[i] = 1'b1;
              press_d[i] = 1'b1;
            end else begin
              state_d[i] = ST_PRESS_WAIT;
            end
          end else begin
            state_d[i] = ST_PRESS_WAIT;
          end
        end
        ST_PRESSED: begin
          if (!sync_q[i]) begin
            state_d[i] = ST_RELEASE_WAIT;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_PRESSED;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_q[i]) begin
            state_d[i] = ST_PRESSED;
          end else if (tick_1ms) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i]   = ST_IDLE;
              level_d[i]   = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              state_d[i] = ST_RELEASE_WAIT;
            end
          end else begin
            state_d[i] = ST_RELEASE_WAIT;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Synchronizer, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      state_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [NUM_BTN-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_BTN-1:0]             hold_q, hold_d;

  // Hold counter saturates at HOLD_TICKS; a release on the same tick suppresses the hold pulse.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (state_q[i] == ST_PRESS_WAIT && state_d[i] == ST_PRESSED) begin
        hold_cnt_d[i] = '0;
      end else if (tick_1ms && (state_q[i] == ST_PRESSED || state_q[i] == ST_RELEASE_WAIT) &&
                   hold_cnt_q[i] != HOLD_DONE) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
        hold_d[i]     = (hold_cnt_q[i] == HOLD_LAST) && (state_d[i] != ST_IDLE);
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i];
      end
    end
  end

  // Long-press counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign hold_pulse = hold_q;
`else
  assign hold_pulse = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: segment table with a scoreboard plus latency/reset sequences.
module tb_button_conditioner;

  localparam int NB   = 2;
  localparam int DEB  = 3;
  localparam int HOLD = 5;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_1ms;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, hold_pulse;

  always #5 clk = ~clk;

  button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .hold_pulse(hold_pulse)
  );

  typedef struct {
    logic [1:0] raw;
    int         len;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] hold;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int obs_press[NB], obs_rel[NB], obs_hold[NB];
  int excl_viol;
  int last_press[NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < NB; ch++) begin
      obs_press[ch] = 0;
      obs_rel[ch]   = 0;
      obs_hold[ch]  = 0;
    end
    excl_viol = 0;
  endtask

  // Sample the result of edge 'cyc', then drive the inputs for edge 'cyc+1'; tick every 4th edge.
  task automatic step(input logic [1:0] raw, input logic r);
    @(negedge clk);
    for (int ch = 0; ch < NB; ch++) begin
      obs_press[ch] += int'(press_pulse[ch]);
      obs_rel[ch]   += int'(release_pulse[ch]);
      obs_hold[ch]  += int'(hold_pulse[ch]);
      if (press_pulse[ch]) last_press[ch] = cyc;
      if ((int'(press_pulse[ch]) + int'(release_pulse[ch]) + int'(hold_pulse[ch])) > 1) excl_viol++;
    end
    cyc++;
    btn_raw  = raw;
    rst      = r;
    tick_1ms = (cyc % 4 == 3);
  endtask

  // Button 0 first seen high (rst low) at edge c0: expect press on the 3rd tick from edge c0+3.
  task automatic measure_press(input int c0, input string tag);
    int n, c3, seen;
    logic lvl_at_seen;
    n = 0;
    c3 = c0 + 3;
    while (1) begin
      if (c3 % 4 == 3) begin
        n++;
        if (n == DEB) break;
      end
      c3++;
    end
    seen = -1;
    lvl_at_seen = 1'b0;
    clear_obs();
    for (int k = 0; k < 40 && seen < 0; k++) begin
      step(2'b01, 1'b0);
      if (press_pulse[0]) begin
        seen = cyc - 1;
        lvl_at_seen = btn_level[0];
      end
    end
    check({tag, "_press_edge"}, seen, c3);
    check({tag, "_level"}, lvl_at_seen, 1'b1);
    check({tag, "_ch1_quiet"}, obs_press[1] + obs_rel[1] + obs_hold[1], 0);
    check({tag, "_no_release"}, obs_rel[0], 0);
  endtask

  initial begin
    vec_t v, e;
    rst = 1'b1;
    btn_raw = 2'b00;
    tick_1ms = 1'b0;
    for (int ch = 0; ch < NB; ch++) last_press[ch] = -1;

    // Reset state
    for (int k = 0; k < 3; k++) step(2'b00, 1'b1);
    step(2'b00, 1'b0);
    check("reset_level", btn_level, 2'b00);
    check("reset_press", press_pulse, 2'b00);
    check("reset_release", release_pulse, 2'b00);
    check("reset_hold", hold_pulse, 2'b00);
    for (int k = 0; k < 20; k++) step(2'b00, 1'b0);

    // Clean press latency on channel 0
    step(2'b01, 1'b0);
    measure_press(cyc, "clean");

    // Reset mid-press: outputs drop without release, then a fresh debounce
    step(2'b01, 1'b1);
    clear_obs();
    step(2'b01, 1'b0);
    check("rst_mid_level", btn_level, 2'b00);
    check("rst_mid_pulses", {press_pulse, release_pulse, hold_pulse}, 6'b0);
    check("rst_mid_no_release", obs_rel[0], 0);
    measure_press(cyc, "after_rst");

    // raw, len, level, press, rel, hold per segment
    vecs.push_back('{2'b01, 60, 2'b01, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{2'b00,  4, 2'b01, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b01, 30, 2'b01, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b00, 30, 2'b00, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{2'b01,  4, 2'b00, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b01, 60, 2'b01, 2'b01, 2'b00, 2'b01});
    vecs.push_back('{2'b00, 30, 2'b00, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{2'b10, 60, 2'b10, 2'b10, 2'b00, 2'b10});
    vecs.push_back('{2'b10, 40, 2'b10, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{2'b00, 30, 2'b00, 2'b00, 2'b10, 2'b00});
    vecs.push_back('{2'b11, 60, 2'b11, 2'b11, 2'b00, 2'b11});
    vecs.push_back('{2'b00, 30, 2'b00, 2'b00, 2'b11, 2'b00});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.hold = v.hold & {2{HOLD_EN}};
      sb.push_back(v);
      clear_obs();
      for (int k = 0; k < v.len; k++) step(v.raw, 1'b0);
      e = sb.pop_front();
      check($sformatf("seg%0d_level", i), btn_level, e.level);
      for (int ch = 0; ch < NB; ch++) begin
        check($sformatf("seg%0d_press%0d", i, ch), obs_press[ch], e.press[ch]);
        check($sformatf("seg%0d_release%0d", i, ch), obs_rel[ch], e.rel[ch]);
        check($sformatf("seg%0d_hold%0d", i, ch), obs_hold[ch], e.hold[ch]);
      end
      check($sformatf("seg%0d_exclusive", i), excl_viol, 0);
      if (i == 11) check("simultaneous_press_edge", last_press[1], last_press[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
